mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Responder end of the MEM-stage RAM request interface and of the IF fetch port.
//  Serialises 32-bit word reads and byte/half/word writes onto the 8-bit
//  single-port RAM bus (1-cycle read latency).
//  Returns ram_done/ram_busy/ram_r_data to MEM and if_done/if_inst to IF.
// PARAMETERS
//  ADDR_W   17  width of mem_a_o; request addresses are truncated to ADDR_W bits
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       reset, synchronous, active-low
//  ram_r_enable_i  in   1       MEM word read request (level, held until done)
//  ram_w_enable_i  in   1       MEM store request (level, held until done)
//  ram_addr_i      in   32      MEM address (word-aligned for reads)
//  ram_w_data_i    in   32      store data; byte i = bits [8i+7:8i]
//  ram_mask_i      in   2       store size: 01 byte, 10 half, 11 word (00 = ignore)
//  ram_done_o      out  1       1-cycle pulse: MEM request complete
//  ram_busy_o      out  1       controller serving a request
//  ram_r_data_o    out  32      read word, valid while ram_done_o=1
//  if_r_enable_i   in   1       IF fetch request (level)
//  if_addr_i       in   32      fetch address, word-aligned
//  if_done_o       out  1       1-cycle pulse: fetch complete
//  if_inst_o       out  32      fetched word, valid while if_done_o=1
//  mem_din_i       in   8       RAM read byte for the address driven the previous cycle
//  mem_dout_o      out  8       RAM write byte
//  mem_a_o         out  ADDR_W  RAM byte address
//  mem_wr_o        out  1       1 = write mem_dout_o to mem_a_o this cycle
// BEHAVIOUR
//  Reset (rst=0 at an edge): state IDLE, cnt=0; all outputs 0. Abort any
//   in-flight op: no done pulse, mem_wr_o drops next cycle.
//  FSM: IDLE -> RD | WR -> DONE -> IDLE. Requests are sampled only in IDLE.
//   DONE is never skipped, so a still-high enable in DONE is never re-accepted.
//  Arbitration in IDLE: MEM store > MEM read > IF fetch. Owner is latched.
//   r_en and w_en both high: store wins.
//  Read (owner MEM or IF), accepted at edge of cycle T, base = addr & ~3:
//   - RD lasts T+1..T+5, cnt 0..4; mem_a_o = base+cnt for cnt<=3.
//   - byte cnt-1 is captured from mem_din_i at cnt 1..4; little-endian assembly.
//   - DONE at T+6: owner's done=1; word on r_data/inst. busy=1 during RD only.
//  Write accepted at T: n = 1/2/4 from mask.
//   - WR lasts T+1..T+n: mem_wr_o=1, mem_a_o = addr+cnt, mem_dout_o = w_data byte cnt.
//   - DONE at T+n+1. Unaligned addresses are written as given, no fault.
//  Address arithmetic is modulo 2^ADDR_W (wraps at top).
//  Idle/DONE: mem_wr_o=0, mem_a_o=0, mem_dout_o=0. Data outputs hold their last
//   value outside done.
//  IF done pulses never coincide with MEM done pulses.
// CONFIGURATION
//  MEM_CTRL_FAST_WR_EN defined: store done pulses at T+1 (first WR cycle).
//   - WR still drains n bytes; DONE state is skipped, WR returns straight to IDLE.
//   - ram_busy_o stays 1 until drain ends, holding off the next MEM and IF request.
//  Undefined: store timing as in BEHAVIOUR.
// STRUCTURE
//  defines.vh: state encodings (IDLE/RD/WR/DONE), mask codes, owner codes (MEM/IF).
//  Sub-module mem_byte_seq: cnt, base address, per-cycle mem_a/mem_wr/mem_dout,
//   4-byte assembly shift register. The top holds the FSM and arbitration.
// TESTING
//  - MEM read 0x100; RAM[0x100..3]=11 22 33 44 -> done at T+6, r_data=0x44332211, busy 5 cycles.
//  - MEM SB addr 0x203, w_data 0xABABABAB -> one write 0xAB @0x203, done at T+2.
//  - MEM SW 0x1FFFF with ADDR_W=17 -> bytes at 0x1FFFF,0x0,0x1,0x2; done at T+5.
//  - IF fetch and MEM read high in the same IDLE cycle -> MEM done first; IF accepted after DONE.
//  - rst=0 at RD cnt=2 -> outputs 0 next cycle; no done; new read afterwards still correct.
//  - FAST_WR_EN, SH 0x10 then LW -> done at T+1, busy 2 cycles; LW accepted only after drain.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM/IF RAM controller: FSM states, request
// owners, store-size codes and the store-length decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_MEM = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_BYTE = 2'b01;
  localparam logic [1:0] MASK_HALF = 2'b10;
  localparam logic [1:0] MASK_WORD = 2'b11;

  // Counter value of the final read cycle: four address cycles plus one
  // cycle to catch the last byte coming back from the RAM.
  localparam logic [2:0] RD_LAST_CNT = 3'd4;

  // Number of bus bytes a store occupies.
  function automatic logic [2:0] mask_len(input logic [1:0] mask);
    case (mask)
      MASK_BYTE: return 3'd1;
      MASK_HALF: return 3'd2;
      MASK_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the 8-bit RAM bus: holds the byte counter, the latched
// base address and store data, drives the per-cycle RAM address/write/data,
// and assembles four returned bytes into a little-endian word.
module mem_byte_seq #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_rd_i,
  input  logic              start_wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       w_data_i,
  input  logic              rd_active_i,
  input  logic              wr_active_i,
  input  logic [7:0]        mem_din_i,
  output logic [2:0]        cnt_o,
  output logic [31:0]       word_o,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);
  import mem_ctrl_pkg::*;

  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] cnt_ext;

  assign cnt_ext = ADDR_W'(cnt_q);
  assign cnt_o   = cnt_q;
  // Only three bytes are stored; the fourth is taken straight off the bus
  // in the last read cycle so the word is ready without an extra cycle.
  assign word_o  = {mem_din_i, asm_q};

  // Next-state for counter, latched address/data and the assembly register.
  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    if (start_rd_i) begin
      base_d = {addr_i[ADDR_W-1:2], 2'b00};
      cnt_d  = 3'd0;
    end else if (start_wr_i) begin
      base_d  = addr_i;
      wdata_d = w_data_i;
      cnt_d   = 3'd0;
    end else if (rd_active_i || wr_active_i) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (rd_active_i && (cnt_q != 3'd0) && (cnt_q != RD_LAST_CNT)) begin
      asm_d = {mem_din_i, asm_q[23:8]};
    end
  end

  // Sequencer registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= 3'd0;
      base_q  <= '0;
      wdata_q <= 32'd0;
      asm_q   <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
    end
  end

  // RAM bus drive: quiet (all zero) unless a read address or write byte is due.
  always_comb begin
    mem_a_o    = '0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'd0;
    if (wr_active_i) begin
      mem_wr_o   = 1'b1;
      mem_a_o    = base_q + cnt_ext;
      mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end else if (rd_active_i && (cnt_q <= 3'd3)) begin
      mem_a_o = base_q + cnt_ext;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage / IF-fetch responder that serialises word reads and
// byte/half/word stores onto an 8-bit single-port RAM (1-cycle read latency).
// Optional build macro MEM_CTRL_FAST_WR_EN: a store reports done in its first
// write cycle and returns to IDLE directly after draining, with busy held high
// until the last byte is written.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_r_enable_i,
  input  logic              ram_w_enable_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_w_data_i,
  input  logic [1:0]        ram_mask_i,
  output logic              ram_done_o,
  output logic              ram_busy_o,
  output logic [31:0]       ram_r_data_o,
  input  logic              if_r_enable_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);
  import mem_ctrl_pkg::*;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        wlen_q, wlen_d;
  logic [31:0]       r_data_q, r_data_d;
  logic [31:0]       if_inst_q, if_inst_d;

  logic              take_wr, take_rd, take_if;
  logic              start_rd, start_wr;
  logic              rd_last, wr_last;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        cnt;
  logic [31:0]       word;
  logic              unused_addr_hi;

  // Fixed priority: store over read over fetch; a store with no size is ignored.
  assign take_wr  = ram_w_enable_i && (ram_mask_i != MASK_NONE);
  assign take_rd  = !take_wr && ram_r_enable_i;
  assign take_if  = !take_wr && !ram_r_enable_i && if_r_enable_i;
  assign req_addr = take_if ? if_addr_i[ADDR_W-1:0] : ram_addr_i[ADDR_W-1:0];
  assign start_wr = (state_q == ST_IDLE) && take_wr;
  assign start_rd = (state_q == ST_IDLE) && (take_rd || take_if);
  assign rd_last  = (state_q == ST_RD) && (cnt == RD_LAST_CNT);
  assign wr_last  = (state_q == ST_WR) && ((cnt + 3'd1) == wlen_q);

  // Address bits above the RAM width are deliberately dropped.
  assign unused_addr_hi = ^{ram_addr_i[31:ADDR_W], if_addr_i[31:ADDR_W]};

  mem_byte_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start_rd_i  (start_rd),
    .start_wr_i  (start_wr),
    .addr_i      (req_addr),
    .w_data_i    (ram_w_data_i),
    .rd_active_i (state_q == ST_RD),
    .wr_active_i (state_q == ST_WR),
    .mem_din_i   (mem_din_i),
    .cnt_o       (cnt),
    .word_o      (word),
    .mem_dout_o  (mem_dout_o),
    .mem_a_o     (mem_a_o),
    .mem_wr_o    (mem_wr_o)
  );

  // Next-state: arbitration in IDLE, sequencing through RD/WR and DONE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wlen_d  = wlen_q;
    case (state_q)
      ST_IDLE: begin
        if (take_wr) begin
          state_d = ST_WR;
          owner_d = OWN_MEM;
          wlen_d  = mask_len(ram_mask_i);
        end else if (take_rd) begin
          state_d = ST_RD;
          owner_d = OWN_MEM;
        end else if (take_if) begin
          state_d = ST_RD;
          owner_d = OWN_IF;
        end
      end
      ST_RD: if (rd_last) state_d = ST_DONE;
`ifdef MEM_CTRL_FAST_WR_EN
      ST_WR: if (wr_last) state_d = ST_IDLE;
`else
      ST_WR: if (wr_last) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result capture: the assembled word lands in the owner's output register.
  always_comb begin
    r_data_d  = r_data_q;
    if_inst_d = if_inst_q;
    if (rd_last) begin
      if (owner_q == OWN_MEM) r_data_d = word;
      else                    if_inst_d = word;
    end
  end

  // Control and result registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_MEM;
      wlen_q    <= 3'd0;
      r_data_q  <= 32'd0;
      if_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wlen_q    <= wlen_d;
      r_data_q  <= r_data_d;
      if_inst_q <= if_inst_d;
    end
  end

  assign ram_busy_o   = (state_q == ST_RD) || (state_q == ST_WR);
  assign if_done_o    = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign ram_r_data_o = r_data_q;
  assign if_inst_o    = if_inst_q;
`ifdef MEM_CTRL_FAST_WR_EN
  // Stores acknowledge on their first bus byte; only reads reach DONE.
  assign ram_done_o = ((state_q == ST_DONE) && (owner_q == OWN_MEM)) ||
                      ((state_q == ST_WR) && (cnt == 3'd0));
`else
  assign ram_done_o = (state_q == ST_DONE) && (owner_q == OWN_MEM);
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model on the bus side, a
// byte-array reference memory updated from request semantics, and per-feature
// test tasks with randomized traffic.
module tb_mem_ctrl;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_CTRL_FAST_WR_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ram_r_en, ram_w_en;
  logic [31:0]   ram_addr, ram_w_data;
  logic [1:0]    ram_mask;
  logic          ram_done, ram_busy;
  logic [31:0]   ram_r_data;
  logic          if_en;
  logic [31:0]   if_addr;
  logic          if_done;
  logic [31:0]   if_inst;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  int n_cmp;
  int n_bad;
  logic [31:0] seed;

  bit [7:0] ram     [DEPTH];
  bit       ram_w   [DEPTH];
  bit [7:0] ref_mem [DEPTH];
  bit       ref_w   [DEPTH];
  logic [AW-1:0] wlog_a[$];
  logic [7:0]    wlog_d[$];

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_r_enable_i (ram_r_en),
    .ram_w_enable_i (ram_w_en),
    .ram_addr_i     (ram_addr),
    .ram_w_data_i   (ram_w_data),
    .ram_mask_i     (ram_mask),
    .ram_done_o     (ram_done),
    .ram_busy_o     (ram_busy),
    .ram_r_data_o   (ram_r_data),
    .if_r_enable_i  (if_en),
    .if_addr_i      (if_addr),
    .if_done_o      (if_done),
    .if_inst_o      (if_inst),
    .mem_din_i      (mem_din),
    .mem_dout_o     (mem_dout),
    .mem_a_o        (mem_a),
    .mem_wr_o       (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of any never-written RAM byte.
  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    logic [31:0] h;
    h = ({15'd0, a} * 32'h9E37_79B1) ^ seed;
    return h[20:13];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
    return ref_w[a] ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [AW-1:0] b;
    b = {addr[AW-1:2], 2'b00};
    return {ref_byte(b + 17'd3), ref_byte(b + 17'd2), ref_byte(b + 17'd1), ref_byte(b)};
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] data, input int n);
    logic [AW-1:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = addr[AW-1:0] + AW'(i);
      ref_mem[idx] = data[8*i +: 8];
      ref_w[idx]   = 1'b1;
    end
  endtask

  // Single-port byte RAM: data for the address of the previous cycle.
  always @(posedge clk) begin
    mem_din <= ram_w[mem_a] ? ram[mem_a] : init_byte(mem_a);
    if (mem_wr) begin
      ram[mem_a]   <= mem_dout;
      ram_w[mem_a] <= 1'b1;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  // kind: 0 = MEM load word, 1 = MEM store, 2 = IF fetch
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] mask, input string tag);
    int n, exp_lat, exp_busy, lat, busy_cnt, guard, wstart;
    logic [31:0] exp_word, got_word;
    logic [AW-1:0] ea;
    bit got, stray;
    n        = (mask == 2'b01) ? 1 : (mask == 2'b10) ? 2 : 4;
    exp_word = ref_word(addr);
    if (kind == 1) begin
      exp_busy = n;
      exp_lat  = FAST ? 1 : n + 1;
    end else begin
      exp_busy = 5;
      exp_lat  = 6;
    end
    wstart = wlog_a.size();
    case (kind)
      0: begin ram_addr = addr; ram_r_en = 1'b1; end
      1: begin ram_addr = addr; ram_w_data = data; ram_mask = mask; ram_w_en = 1'b1; end
      default: begin if_addr = addr; if_en = 1'b1; end
    endcase
    lat = 0; busy_cnt = 0; got = 0; stray = 0; got_word = 32'd0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ram_busy) busy_cnt++;
      if (kind == 2) begin
        if (ram_done) stray = 1;
        if (if_done) begin got = 1; got_word = if_inst; end
      end else begin
        if (if_done) stray = 1;
        if (ram_done) begin got = 1; got_word = ram_r_data; end
      end
    end
    ram_r_en = 1'b0; ram_w_en = 1'b0; if_en = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s done_timeout: no done within %0d cycles, required a pulse", tag, lat);
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, lat, exp_lat);
    end
    if (kind != 1) begin
      n_cmp++;
      if (got_word !== exp_word) begin
        n_bad++;
        $display("FAIL %s read_data: got %h, required %h", tag, got_word, exp_word);
      end
    end
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
      if (ram_busy) busy_cnt++;
      if (ram_done || if_done) stray = 1;
    end while (ram_busy && guard < 20);
    n_cmp++;
    if (busy_cnt != exp_busy) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", tag, busy_cnt, exp_busy);
    end
    n_cmp++;
    if (stray) begin
      n_bad++;
      $display("FAIL %s stray_done: got extra/wrong done pulse, required none", tag);
    end
    if (kind == 1) begin
      n_cmp++;
      if (wlog_a.size() - wstart != n) begin
        n_bad++;
        $display("FAIL %s write_count: got %0d bus writes, required %0d", tag,
                 wlog_a.size() - wstart, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          ea = addr[AW-1:0] + AW'(i);
          n_cmp++;
          if (wlog_a[wstart+i] !== ea || wlog_d[wstart+i] !== data[8*i +: 8]) begin
            n_bad++;
            $display("FAIL %s write_byte%0d: got %h@%h, required %h@%h", tag, i,
                     wlog_d[wstart+i], wlog_a[wstart+i], data[8*i +: 8], ea);
          end
        end
      end
      ref_store(addr, data, n);
    end
    $display("txn %s kind=%0d addr=%h wdata=%h mask=%b lat=%0d busy=%0d rdata=%h",
             tag, kind, addr, data, mask, lat, busy_cnt, got_word);
  endtask

  task automatic check_quiet(input string tag);
    n_cmp++;
    if ({ram_done, if_done, ram_busy, mem_wr} !== 4'b0 || mem_a !== '0 || mem_dout !== 8'd0) begin
      n_bad++;
      $display("FAIL %s bus_quiet: got done=%b ifd=%b busy=%b wr=%b a=%h d=%h, required all 0",
               tag, ram_done, if_done, ram_busy, mem_wr, mem_a, mem_dout);
    end
    n_cmp++;
    if (ram_r_data !== 32'd0 || if_inst !== 32'd0) begin
      n_bad++;
      $display("FAIL %s data_cleared: got r_data=%h inst=%h, required 0", tag, ram_r_data, if_inst);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ram_r_en = 0; ram_w_en = 0; if_en = 0;
    ram_addr = 0; ram_w_data = 0; ram_mask = 0; if_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_directed;
    run_op(1, 32'h0000_0100, 32'h4433_2211, 2'b11, "sw_0x100");
    run_op(0, 32'h0000_0100, 32'h0, 2'b00, "lw_0x100");
    n_cmp++;
    if (ram_r_data !== 32'h4433_2211) begin
      n_bad++;
      $display("FAIL lw_0x100_value: got %h, required 44332211", ram_r_data);
    end
    run_op(1, 32'h0000_0203, 32'hABAB_ABAB, 2'b01, "sb_0x203");
    run_op(1, 32'h0001_FFFF, 32'hC3B2_A190, 2'b11, "sw_wrap");
    run_op(0, 32'h0001_FFFC, 32'h0, 2'b00, "lw_top");
    run_op(0, 32'h0000_0000, 32'h0, 2'b00, "lw_zero");
    run_op(2, 32'hFFFE_0200, 32'h0, 2'b00, "if_trunc");
  endtask

  task automatic test_arbitration;
    int e, mem_at, if_at;
    bit coincide;
    logic [31:0] mw, iw, exp_m, exp_i;
    exp_m = ref_word(32'h300);
    exp_i = ref_word(32'h404);
    ram_addr = 32'h300; if_addr = 32'h404;
    ram_r_en = 1'b1; if_en = 1'b1;
    e = 0; mem_at = -1; if_at = -1; coincide = 0; mw = 0; iw = 0;
    while (if_at < 0 && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (ram_done && if_done) coincide = 1;
      if (ram_done) begin mem_at = e; mw = ram_r_data; ram_r_en = 1'b0; end
      if (if_done) begin if_at = e; iw = if_inst; if_en = 1'b0; end
    end
    ram_r_en = 1'b0; if_en = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_at != 6) begin n_bad++; $display("FAIL arb_mem_first: got done at %0d, required 6", mem_at); end
    n_cmp++;
    if (if_at != 13) begin n_bad++; $display("FAIL arb_if_after: got done at %0d, required 13", if_at); end
    n_cmp++;
    if (mw !== exp_m) begin n_bad++; $display("FAIL arb_mem_data: got %h, required %h", mw, exp_m); end
    n_cmp++;
    if (iw !== exp_i) begin n_bad++; $display("FAIL arb_if_data: got %h, required %h", iw, exp_i); end
    n_cmp++;
    if (coincide) begin n_bad++; $display("FAIL arb_overlap: got coincident done pulses, required none"); end
    $display("txn arbitration mem_done=%0d if_done=%0d", mem_at, if_at);
  endtask

  task automatic test_reset_mid;
    bit seen;
    ram_addr = 32'h100; ram_r_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (ram_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b, required 1", ram_busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    check_quiet("rst_mid_rd");
    rst = 1'b1; ram_r_en = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (ram_done || if_done || ram_busy) seen = 1; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rst_mid_no_done: got activity after abort, required none"); end
    run_op(0, 32'h100, 32'h0, 2'b00, "lw_after_rst");
    // abort a word store after two bytes reached the bus
    ram_addr = 32'h500; ram_w_data = 32'h5566_7788; ram_mask = 2'b11; ram_w_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_wr !== 1'b0 || ram_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_wr: got wr=%b busy=%b, required 0/0", mem_wr, ram_busy);
    end
    rst = 1'b1; ram_w_en = 1'b0;
    ref_store(32'h500, 32'h5566_7788, 2);
    @(posedge clk); #1;
    run_op(0, 32'h500, 32'h0, 2'b00, "lw_part_sw");
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, busy_cnt, wstart;
    logic [31:0] exp_word, got_word;
    logic [15:0] hd;
    hd = 16'($urandom);
    wstart = wlog_a.size();
    ram_addr = 32'h10; ram_w_data = {16'h0, hd}; ram_mask = 2'b10; ram_w_en = 1'b1;
    lat1 = 0; busy_cnt = 0;
    while (lat1 < 40) begin
      @(posedge clk); #1; lat1++;
      if (ram_busy) busy_cnt++;
      if (ram_done) break;
    end
    ram_w_en = 1'b0; ram_r_en = 1'b1;
    ref_store(32'h10, {16'h0, hd}, 2);
    exp_word = ref_word(32'h10);
    lat2 = 0; got_word = 0;
    while (lat2 < 40) begin
      @(posedge clk); #1; lat2++;
      if (ram_busy) busy_cnt++;
      if (ram_done) begin got_word = ram_r_data; break; end
    end
    ram_r_en = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (lat1 != (FAST ? 1 : 3)) begin
      n_bad++; $display("FAIL b2b_sh_latency: got %0d, required %0d", lat1, FAST ? 1 : 3);
    end
    n_cmp++;
    if (lat2 != (FAST ? 8 : 7)) begin
      n_bad++; $display("FAIL b2b_lw_latency: got %0d, required %0d", lat2, FAST ? 8 : 7);
    end
    n_cmp++;
    if (got_word !== exp_word) begin
      n_bad++; $display("FAIL b2b_lw_data: got %h, required %h", got_word, exp_word);
    end
    n_cmp++;
    if (busy_cnt != 7) begin
      n_bad++; $display("FAIL b2b_busy: got %0d, required 7", busy_cnt);
    end
    n_cmp++;
    if (wlog_a.size() - wstart != 2) begin
      n_bad++; $display("FAIL b2b_sh_writes: got %0d, required 2", wlog_a.size() - wstart);
    end
    $display("txn back_to_back sh_lat=%0d lw_lat=%0d data=%h", lat1, lat2, got_word);
  endtask

  task automatic test_random;
    int kind;
    logic [31:0] a, d;
    logic [1:0] m;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31:17], 17'h1FFFC} | 32'($urandom_range(0, 3));
      d = $urandom;
      m = 2'($urandom_range(1, 3));
      if (kind != 1) a = a & 32'hFFFF_FFFC;
      run_op(kind, a, d, m, $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    seed  = $urandom;
    test_reset;
    test_directed;
    test_arbitration;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
